// File: rtl/stream_pkg.sv
// Shared types, FSM encoding and byte-order helpers for the 16-to-8 stream unpacker.
package stream_pkg;

    typedef logic [15:0] word16_t;
    typedef logic [7:0]  byte8_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B0   = 2'd1,
        B1   = 2'd2,
        CSUM = 2'd3
    } unpack_state_t;

    localparam logic BYTE_LO_FIRST = 1'b0;
    localparam logic BYTE_HI_FIRST = 1'b1;

    // idx is the emission slot (0 = first byte out); hi_first flips which half that is.
    function automatic byte8_t pick_byte(input word16_t w, input logic hi_first, input logic idx);
        pick_byte = ((idx ^ hi_first) == 1'b1) ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry word FIFO with a registered write-ready that already accounts for a same-cycle pop.
module skid_fifo2
    import stream_pkg::*;
(
    input  logic       aclk_i,
    input  logic       aresetn_i,
    input  word16_t    wr_data_i,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    input  logic       pop_i,
    output word16_t    head_o,
    output word16_t    next_o,
    output logic [1:0] count_o
);

    word16_t    mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       ready_q;
    logic       ready_d;
    logic       push_s;

    assign push_s = wr_valid_i & ready_q;

    // Next occupancy and the ready value it implies for the following cycle.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_i) begin
            count_d = count_q + 2'd1;
        end else if (!push_s && pop_i) begin
            count_d = count_q - 2'd1;
        end else begin
            count_d = count_q;
        end
        ready_d = (count_d != 2'd2);
    end

    // Storage, pointers and registered ready.
    always_ff @(posedge aclk_i) begin
        if (!aresetn_i) begin
            mem_q[0] <= 16'd0;
            mem_q[1] <= 16'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= ready_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign wr_ready_o = ready_q;
    assign head_o     = mem_q[rd_ptr_q];
    assign next_o     = mem_q[~rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/stream_unpack16to8.sv
// Serializes 16-bit stream words into byte beats with frame marking.
// Define STREAM_UNPACK_CHECKSUM_EN to append a mod-256 checksum byte after each frame.
module stream_unpack16to8
    import stream_pkg::*;
#(
    parameter int   FRAME_LEN = 8,
    parameter logic HI_FIRST  = BYTE_LO_FIRST
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [15:0] in_tdata,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [7:0]  out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tlast
);

    localparam byte8_t LAST_IDX = byte8_t'(FRAME_LEN - 1);

    unpack_state_t state_q;
    byte8_t        out_tdata_q;
    logic          out_tvalid_q;
    logic          out_tlast_q;
    byte8_t        word_cnt_q;

    word16_t       head_s;
    word16_t       next_s;
    logic [1:0]    count_s;
    logic          fifo_ne_s;
    logic          out_acc_s;
    logic          pop_s;
    logic          last_word_s;
    logic          csum_due_s;
    logic          tlast_b1_s;
    byte8_t        csum_byte_s;

    skid_fifo2 u_fifo (
        .aclk_i     (aclk),
        .aresetn_i  (aresetn),
        .wr_data_i  (in_tdata),
        .wr_valid_i (in_tvalid),
        .wr_ready_o (in_tready),
        .pop_i      (pop_s),
        .head_o     (head_s),
        .next_o     (next_s),
        .count_o    (count_s)
    );

    assign fifo_ne_s   = (count_s != 2'd0);
    assign out_acc_s   = out_tvalid_q & out_tready;
    // The head word stays in the FIFO until its final byte is taken.
    assign pop_s       = (state_q == B1) & out_acc_s;
    assign last_word_s = (word_cnt_q == LAST_IDX);

`ifdef STREAM_UNPACK_CHECKSUM_EN
    byte8_t csum_q;

    assign csum_byte_s = csum_q + out_tdata_q;
    assign csum_due_s  = last_word_s;
    assign tlast_b1_s  = 1'b0;
`else
    assign csum_byte_s = 8'd0;
    assign csum_due_s  = 1'b0;
    assign tlast_b1_s  = last_word_s;
`endif

    // Sequencer with registered output beat, word counter and checksum.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            out_tdata_q  <= 8'd0;
            out_tvalid_q <= 1'b0;
            out_tlast_q  <= 1'b0;
            word_cnt_q   <= 8'd0;
`ifdef STREAM_UNPACK_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_ne_s) begin
                        out_tdata_q  <= pick_byte(head_s, HI_FIRST, 1'b0);
                        out_tvalid_q <= 1'b1;
                        out_tlast_q  <= 1'b0;
                        state_q      <= B0;
                    end
                end
                B0: begin
                    if (out_acc_s) begin
`ifdef STREAM_UNPACK_CHECKSUM_EN
                        csum_q      <= csum_q + out_tdata_q;
`endif
                        out_tdata_q <= pick_byte(head_s, HI_FIRST, 1'b1);
                        out_tlast_q <= tlast_b1_s;
                        state_q     <= B1;
                    end
                end
                B1: begin
                    if (out_acc_s) begin
                        word_cnt_q <= last_word_s ? 8'd0 : word_cnt_q + 8'd1;
`ifdef STREAM_UNPACK_CHECKSUM_EN
                        csum_q     <= csum_byte_s;
`endif
                        if (csum_due_s) begin
                            out_tdata_q <= csum_byte_s;
                            out_tlast_q <= 1'b1;
                            state_q     <= CSUM;
                        end else if (count_s == 2'd2) begin
                            // Second entry becomes the head after this pop.
                            out_tdata_q <= pick_byte(next_s, HI_FIRST, 1'b0);
                            out_tlast_q <= 1'b0;
                            state_q     <= B0;
                        end else begin
                            out_tdata_q  <= 8'd0;
                            out_tvalid_q <= 1'b0;
                            out_tlast_q  <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end
                end
`ifdef STREAM_UNPACK_CHECKSUM_EN
                CSUM: begin
                    if (out_acc_s) begin
                        csum_q <= 8'd0;
                        if (fifo_ne_s) begin
                            out_tdata_q <= pick_byte(head_s, HI_FIRST, 1'b0);
                            out_tlast_q <= 1'b0;
                            state_q     <= B0;
                        end else begin
                            out_tdata_q  <= 8'd0;
                            out_tvalid_q <= 1'b0;
                            out_tlast_q  <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end
                end
`endif
                default: begin
                    out_tdata_q  <= 8'd0;
                    out_tvalid_q <= 1'b0;
                    out_tlast_q  <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign out_tdata  = out_tdata_q;
    assign out_tvalid = out_tvalid_q;
    assign out_tlast  = out_tlast_q;

endmodule

// File: tb/tb_stream_unpack16to8.sv
// Randomized and directed bench for stream_unpack16to8 against a queue-based byte model.
module tb_stream_unpack16to8;

    localparam int   FL          = 4;
    localparam logic TB_HI_FIRST = 1'b0;
`ifdef STREAM_UNPACK_CHECKSUM_EN
    localparam bit   CSUM_ON     = 1'b1;
`else
    localparam bit   CSUM_ON     = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] in_tdata = 16'd0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [7:0]  out_tdata;
    logic        out_tvalid;
    logic        out_tready = 1'b1;
    logic        out_tlast;

    stream_unpack16to8 #(.FRAME_LEN(FL), .HI_FIRST(TB_HI_FIRST)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast)
    );

    initial forever #5 aclk = ~aclk;

    typedef struct packed { logic [7:0] d; logic l; logic [1:0] k; } exp_t;
    typedef struct packed { logic [7:0] d; logic l; int unsigned e; } got_t;

    exp_t        exp_q[$];
    got_t        got_q[$];
    int unsigned win_q[$];
    int          occ = 0;
    int          wcnt = 0;
    logic [7:0]  sum = 8'd0;
    logic        exp_ready = 1'b0;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          nbytes = 0;
    int          nwords = 0;
    int          ncsum = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_d = 8'd0;
    logic        prev_l = 1'b0;
    bit          drv_done = 1'b0;
    bit          stop_rdy = 1'b0;
    bit          rdy_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_true(input string name, input logic cond);
        checks++;
        if (cond !== 1'b1) begin
            errors++;
            $display("FAIL %s: condition got %0b, required 1", name, cond);
        end
    endtask

    // Expected byte stream for one accepted word: two data bytes, then a checksum at frame end.
    task automatic model_word(input logic [15:0] w);
        logic [7:0] b [2];
        b[0] = TB_HI_FIRST ? w[15:8] : w[7:0];
        b[1] = TB_HI_FIRST ? w[7:0]  : w[15:8];
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{d: b[i], l: (!CSUM_ON && i == 1 && wcnt == FL - 1), k: (i == 1) ? 2'd1 : 2'd0});
            sum = sum + b[i];
        end
        wcnt++;
        if (wcnt == FL) begin
            wcnt = 0;
            if (CSUM_ON) exp_q.push_back('{d: sum, l: 1'b1, k: 2'd2});
            sum = 8'd0;
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Compare process: checks current outputs, then predicts the handshakes of the coming edge.
    always @(negedge aclk) begin : monitor
        exp_t e;
        chk("in_tready", in_tready, exp_ready);
        if (prev_stall) begin
            chk("stall_valid", out_tvalid, 1'b1);
            chk("stall_data", out_tdata, prev_d);
            chk("stall_last", out_tlast, prev_l);
        end
        if (!aresetn) begin
            exp_q.delete();
            occ = 0; wcnt = 0; sum = 8'd0;
            exp_ready = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (out_tvalid && out_tready) begin
                chk_true("byte_expected", exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_tdata", out_tdata, e.d);
                    chk("out_tlast", out_tlast, e.l);
                    if (e.k == 2'd1) occ--;
                    if (e.k == 2'd2) ncsum++;
                end
                nbytes++;
                got_q.push_back('{d: out_tdata, l: out_tlast, e: cyc + 1});
            end
            if (in_tvalid && in_tready) begin
                model_word(in_tdata);
                occ++;
                nwords++;
                win_q.push_back(cyc + 1);
            end
            exp_ready  = (occ < 2);
            prev_stall = out_tvalid && !out_tready;
            prev_d     = out_tdata;
            prev_l     = out_tlast;
        end
    end

    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        in_tdata  = w;
        in_tvalid = 1'b1;
        @(negedge aclk);
        while (!in_tready && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        chk_true("send_accept", in_tready);
        @(posedge aclk); #1;
        in_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || occ != 0) && n < 6000) begin
            @(posedge aclk);
            n++;
        end
        repeat (3) @(posedge aclk);
        #1;
        chk_true("drain", exp_q.size() == 0);
    endtask

    task automatic reset_dut();
        @(posedge aclk); #1;
        aresetn = 1'b0; in_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1; aresetn = 1'b1;
        @(posedge aclk); #1;
        got_q.delete(); win_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_tready"}, in_tready, 1'b0);
        chk({tag, "_out_tvalid"}, out_tvalid, 1'b0);
        chk({tag, "_out_tdata"}, out_tdata, 8'h00);
        chk({tag, "_out_tlast"}, out_tlast, 1'b0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int di;
        int w0, b0, c0;
        int exp_bytes;
        logic [15:0] w;

        @(negedge aclk);
        check_reset_outputs("reset_state");
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("ready_first_edge", in_tready, 1'b1);

        // Single word: byte order and latency.
        got_q.delete(); win_q.delete();
        out_tready = 1'b1;
        send_word(16'h0A01);
        wait_drain();
        chk("t1_count", got_q.size(), 2);
        if (got_q.size() == 2 && win_q.size() == 1) begin
            chk("t1_byte0", got_q[0].d, 8'h01);
            chk("t1_byte1", got_q[1].d, 8'h0A);
            chk("t1_latency", got_q[0].e - win_q[0], 2);
            chk("t1_back_to_back", got_q[1].e - got_q[0].e, 1);
        end

        // Burst of 16 words with the output stalled for the first 4 cycles.
        reset_dut();
        out_tready = 1'b0;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send_word(16'h0A10 + 16'(i));
                drv_done = 1'b1;
            end
        join_none
        repeat (4) @(posedge aclk);
        #1;
        chk("t2_words_held", win_q.size(), 2);
        chk("t2_ready_full", in_tready, 1'b0);
        out_tready = 1'b1;
        for (int n = 0; n < 3000 && !drv_done; n++) @(posedge aclk);
        #1;
        chk_true("t2_driver_done", drv_done);
        wait_drain();
        di = 0;
        foreach (got_q[i]) begin
`ifdef STREAM_UNPACK_CHECKSUM_EN
            if (got_q[i].l) continue;
`endif
            chk("t2_data", got_q[i].d, (di % 2 == 0) ? (32'h10 + 32'(di / 2)) : 32'h0A);
            di++;
        end
        chk("t2_data_count", di, 32);
`ifndef STREAM_UNPACK_CHECKSUM_EN
        for (int i = 1; i < got_q.size(); i++) chk("t2_no_gap", got_q[i].e - got_q[i-1].e, 1);
`endif

        // Frame marking, two frames of 4 words.
        reset_dut();
        for (int i = 0; i < 8; i++) send_word(16'h0A00 + 16'(i));
        wait_drain();
`ifdef STREAM_UNPACK_CHECKSUM_EN
        chk("t4_count", got_q.size(), 18);
        if (got_q.size() == 18) begin
            chk("t4_csum0", got_q[8].d, 8'h2E);
            chk("t4_csum0_last", got_q[8].l, 1'b1);
            chk("t4_csum1", got_q[17].d, 8'h3E);
            chk("t4_csum1_last", got_q[17].l, 1'b1);
            for (int i = 0; i < 8; i++) chk("t4_data_last", got_q[i].l, 1'b0);
        end
`else
        chk("t3_count", got_q.size(), 16);
        if (got_q.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("t3_last", got_q[i].l, (i == 7 || i == 15) ? 1'b1 : 1'b0);
            chk("t3_byte8", got_q[7].d, 8'h0A);
            chk("t3_byte16", got_q[15].d, 8'h0A);
        end
`endif

        // Random words under random output backpressure.
        reset_dut();
        w0 = nwords; b0 = nbytes; c0 = ncsum;
        drv_done = 1'b0; stop_rdy = 1'b0; rdy_done = 1'b0;
        fork
            begin
                int h, l;
                while (!stop_rdy) begin
                    h = $urandom_range(24, 0);
                    l = $urandom_range(32, 1);
                    out_tready = 1'b1;
                    repeat (h) begin @(posedge aclk); #1; end
                    out_tready = 1'b0;
                    repeat (l) begin @(posedge aclk); #1; end
                end
                rdy_done = 1'b1;
            end
            begin
                logic [15:0] rw;
                for (int i = 0; i < 500; i++) begin
                    repeat ($urandom_range(3, 0)) begin @(posedge aclk); #1; end
                    rw = 16'($urandom);
                    send_word(rw);
                end
                drv_done = 1'b1;
            end
        join_none
        for (int n = 0; n < 40000 && !drv_done; n++) @(posedge aclk);
        stop_rdy = 1'b1;
        for (int n = 0; n < 200 && !rdy_done; n++) @(posedge aclk);
        #1;
        out_tready = 1'b1;
        chk_true("t5_driver_done", drv_done);
        wait_drain();
        exp_bytes = 1000;
`ifdef STREAM_UNPACK_CHECKSUM_EN
        exp_bytes = 1125;
        chk("t5_csums", ncsum - c0, 125);
`endif
        chk("t5_words", nwords - w0, 500);
        chk("t5_bytes", nbytes - b0, exp_bytes);

        // Reset in the middle of a word, then a clean frame.
        reset_dut();
        out_tready = 1'b1;
        send_word(16'h0B01);
        @(posedge aclk); @(posedge aclk); #1;
        chk("t6_byte0_taken", got_q.size(), 1);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        check_reset_outputs("t6_rst1");
        @(posedge aclk); #1;
        check_reset_outputs("t6_rst2");
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("t6_ready_after_rst", in_tready, 1'b1);
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            w = 16'h0C00 + 16'(i);
            send_word(w);
        end
        wait_drain();
`ifdef STREAM_UNPACK_CHECKSUM_EN
        chk("t6_count", got_q.size(), 9);
        if (got_q.size() == 9) chk("t6_csum", got_q[8].d, 8'h36);
`else
        chk("t6_count", got_q.size(), 8);
        if (got_q.size() == 8) chk("t6_final", got_q[7].d, 8'h0C);
`endif
        foreach (got_q[i]) chk("t6_last", got_q[i].l, (i == got_q.size() - 1) ? 1'b1 : 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_unpack16to8.md
# stream_unpack16to8

Downstream byte serializer for the 16-bit lookup stream produced by the credit stage. It accepts 16-bit AXI-Stream words, buffers up to two of them, and emits each word as two 8-bit beats with full backpressure on both sides. It also marks frame boundaries with `out_tlast` and optionally appends a checksum byte. This stage feeds the byte-wide link and the bench scoreboard.

## Interface
- `FRAME_LEN`, 8: words per frame, legal range 1..255.
- `HI_FIRST`, 0: byte order. 0 emits the low byte then the high byte; 1 emits the high byte first.
- `aclk` in 1: single clock; all logic updates on the rising edge.
- `aresetn` in 1: reset, synchronous and active-low.
- `in_tdata` in 16: input word.
- `in_tvalid` in 1: input word valid.
- `in_tready` out 1: registered; asserted when the input buffer has a free entry.
- `out_tdata` out 8: output byte.
- `out_tvalid` out 1: output byte valid.
- `out_tready` in 1: downstream ready.
- `out_tlast` out 1: marks the last byte of a frame.

## Operation
- **Input buffer.** 2-entry FIFO. A push happens on `in_tvalid & in_tready`. `in_tready` is the registered value of `count<2`, corrected for a same-cycle pop, so back-to-back acceptance is possible.
- **Sequencer FSM.** States are `IDLE`, `B0`, `B1`, and `CSUM` (CSUM exists only with the macro).
  - `IDLE` → `B0` when the FIFO is non-empty and the output register is free.
  - `B0` → `B1` when byte 0 is accepted.
  - `B1` → `B0` or `IDLE` when byte 1 is accepted, depending on FIFO occupancy. The FIFO pops at that acceptance.
  - `B1` → `CSUM` instead, when the word just finished was the last of its frame and the macro is on.
- **Output register.** `out_tdata`, `out_tvalid`, and `out_tlast` are registered. While `out_tvalid & ~out_tready`, all three hold stable. A new byte loads in the same cycle the current one is accepted, so there are no bubbles.
- **Word counter.** 8-bit, increments when a word's final data byte is accepted. It wraps to 0 after `FRAME_LEN-1`.
- **Checksum** (macro on). 8-bit wrap-around sum (mod 256) of every data byte in the frame. It clears to 0 when the checksum byte is accepted.
- **Reset.** While `aresetn==0` at the edge:
  - outputs: `in_tready=0`, `out_tvalid=0`, `out_tdata=0`, `out_tlast=0`;
  - state: FSM=`IDLE`, FIFO empty, counter=0, checksum=0.
- **Reset mid-frame.** Any byte in flight is discarded and the partial frame is not completed. After reset the next word starts a new frame.

## Timing
- `in_tready` goes to 1 on the first edge with `aresetn==1`.
- Word accepted at edge N with the output idle → byte 0 is valid after edge N+1. Byte 1 is valid after edge N+2 if byte 0 was accepted at N+2.
- Throughput:
  - 1 byte per cycle sustained with `out_tready` held high;
  - 1 word per 2 cycles at the input;
  - with the macro on, 1 extra cycle per frame.
- FIFO full: `in_tready=0` in the cycle after the second entry is pushed with no pop.
- FIFO simultaneous push and pop: occupancy is unchanged and `in_tready` stays high.
- `out_tready` low for K cycles → output stalls K cycles and data is neither lost nor duplicated. At most 2 words plus the in-flight byte are held.
- `FRAME_LEN=1`: `out_tlast` is on every word's final byte (macro off), or on every checksum byte (macro on).

## Configuration
- Macro `STREAM_UNPACK_CHECKSUM_EN`.
- Defined: after the final data byte of each frame, emit the checksum byte with `out_tlast=1`. Data bytes carry `out_tlast=0`.
- Undefined: there is no `CSUM` state and no checksum register. `out_tlast=1` on the final data byte of the `FRAME_LEN`-th word.

## Structure
- Shared package `stream_pkg`:
  - FSM enum `unpack_state_t` (`IDLE`, `B0`, `B1`, `CSUM`);
  - byte-order constants `BYTE_LO_FIRST`=0 and `BYTE_HI_FIRST`=1;
  - typedefs `word16_t` and `byte8_t`.
- Sub-module `skid_fifo2`: a 2-entry FIFO with registered ready, instantiated for the input buffer.
- The sequencer, word counter, and checksum live in the top module.

## Test plan
1. Single word 0x0A01, `out_tready=1`, `HI_FIRST=0` → bytes 0x01 then 0x0A on consecutive cycles. Byte 0 is valid 1 cycle after acceptance.
2. Burst of 16 words 0x0A10..0x0A1F, `out_tready=0` for the first 4 cycles:
   - `in_tready` drops after 2 words are accepted;
   - after release, 32 bytes arrive in order with no gaps;
   - no loss and no duplicate.
3. `FRAME_LEN=4`, macro off, words 0x0A00..0x0A07 → `out_tlast=1` exactly on the 8th and 16th bytes (0x0A, 0x0A).
4. `FRAME_LEN=4`, macro on, words 0x0A00..0x0A03:
   - 9 bytes are emitted;
   - the 9th byte is 0x2E (sum 0x06+4·0x0A mod 256) with `out_tlast=1`;
   - the next frame's sum restarts from 0.
5. Random `out_tready` (high 0–24 cycles, low 1–32 cycles) with 500 random words → byte scoreboard has 0 errors, and byte count equals 2·words plus checksums.
6. `aresetn` low for 2 cycles mid-frame (after byte 0) →
   - all outputs are 0 during reset;
   - `in_tready=1` on the first edge after release;
   - the next word's bytes are emitted normally, and `out_tlast` comes after `FRAME_LEN` new words.
